// File: rtl/ddr3_tg_pkg.sv
// Shared encodings and helpers for the DDR3 app-interface traffic generator.
package ddr3_tg_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CALIB   = 3'd1;
  localparam logic [2:0] S_WR_CMD  = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_RD_CMD  = 3'd4;
  localparam logic [2:0] S_RD_DATA = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr32_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

endpackage

// File: rtl/ddr3_tg_pattern.sv
// Per-beat data pattern source: counter or LFSR word, replicated across 32-bit lanes as word ^ lane.
module ddr3_tg_pattern
  import ddr3_tg_pkg::*;
#(
  parameter int          DATA_W = 128,
  parameter logic [31:0] SEED   = 32'hACE1_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              adv,
  input  logic              mode_lfsr,
  output logic [DATA_W-1:0] data
);

  logic [31:0] word;
  logic        lfsr_mode;

  // Pattern word: restarted on init, stepped on each advance
  always_ff @(posedge clk) begin
    if (rst) begin
      word      <= 32'd0;
      lfsr_mode <= 1'b0;
    end else if (init) begin
      lfsr_mode <= mode_lfsr;
      word      <= mode_lfsr ? SEED : 32'd0;
    end else if (adv) begin
      word <= lfsr_mode ? lfsr32_next(word) : word + 32'd1;
    end
  end

  // Lane j carries word ^ j
  always_comb begin
    data = '0;
    for (int j = 0; j < DATA_W / 32; j++) begin
      data[j*32 +: 32] = word ^ 32'(j);
    end
  end

endmodule

// File: rtl/ddr3_app_traffic_gen.sv
// Self-checking DDR3 app-interface traffic generator: writes a region in bursts, reads it back
// and compares each beat against a regenerated pattern.
module ddr3_app_traffic_gen
  import ddr3_tg_pkg::*;
#(
  parameter int          ADDR_W        = 27,
  parameter int          DATA_W        = 128,
  parameter int          BURST_BEATS   = 4,
  parameter int          REGION_BURSTS = 256,
  parameter int          ADDR_INC      = 8,
  parameter int unsigned BASE_ADDR     = 0,
  parameter logic [31:0] SEED          = 32'hACE1_0001,
  parameter int          TIMEOUT       = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              init_calib_complete,
  output logic              app_cmd_en,
  output logic [2:0]        app_cmd,
  input  logic              app_cmd_rdy,
  output logic [ADDR_W-1:0] app_addr,
  output logic [5:0]        app_burst_number,
  output logic              app_wdata_en,
  output logic              app_wdata_end,
  output logic [DATA_W-1:0] app_wdata,
  input  logic              app_wdata_rdy,
  input  logic              app_rdata_valid,
  input  logic              app_rdata_end,
  input  logic [DATA_W-1:0] app_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              spurious,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int                BW         = $clog2(REGION_BURSTS + 1);
  localparam int                TW         = $clog2(TIMEOUT + 1);
  localparam logic [5:0]        LAST_BEAT  = 6'(BURST_BEATS - 1);
  localparam logic [BW-1:0]     LAST_BURST = BW'(REGION_BURSTS - 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(BURST_BEATS * ADDR_INC);
  localparam logic [ADDR_W-1:0] BEAT_INC   = ADDR_W'(ADDR_INC);

  logic [2:0]        state;
  logic [BW-1:0]     burst_cnt;
  logic [5:0]        beat_cnt;
  logic              interleaved;
  logic [TW-1:0]     tmo_cnt;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] chk_data;
  logic [ADDR_W-1:0] beat_addr;
  logic start_acc, cmd_acc, wr_acc, rd_beat, active, progress, tmo_hit;
  logic last_beat, last_burst, beat_err;

  assign start_acc  = start && (state == S_IDLE);
  assign cmd_acc    = app_cmd_en && app_cmd_rdy;
  assign wr_acc     = app_wdata_en && app_wdata_rdy;
  assign rd_beat    = app_rdata_valid && (state == S_RD_DATA);
  assign active     = state inside {S_WR_CMD, S_WR_DATA, S_RD_CMD, S_RD_DATA};
  assign progress   = cmd_acc || wr_acc || app_rdata_valid;
  assign tmo_hit    = active && !progress && (tmo_cnt == TW'(TIMEOUT - 1));
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign last_burst = (burst_cnt == LAST_BURST);
  assign beat_addr  = app_addr + ADDR_W'(beat_cnt) * BEAT_INC;
  // An rdata_end that disagrees with our own beat count counts as a bad beat
  assign beat_err   = (app_rdata != chk_data) || (app_rdata_end != last_beat);

  assign app_burst_number = LAST_BEAT;
  assign app_wdata        = app_wdata_en ? wr_data : '0;

  ddr3_tg_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_pat (
    .clk(clk), .rst(rst), .init(start_acc), .adv(wr_acc), .mode_lfsr(mode[1]), .data(wr_data)
  );

  ddr3_tg_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_chk_pat (
    .clk(clk), .rst(rst), .init(start_acc), .adv(rd_beat), .mode_lfsr(mode[1]), .data(chk_data)
  );

  // Test sequencer, app-interface drivers, checker and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      burst_cnt      <= '0;
      beat_cnt       <= 6'd0;
      interleaved    <= 1'b0;
      tmo_cnt        <= '0;
      app_cmd_en     <= 1'b0;
      app_cmd        <= CMD_WR;
      app_addr       <= '0;
      app_wdata_en   <= 1'b0;
      app_wdata_end  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      spurious       <= 1'b0;
      err_count      <= 16'd0;
      first_err_addr <= '0;
    end else begin
      if (!active || progress) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_cnt + TW'(1);

      if (app_rdata_valid && state != S_RD_DATA && state != S_IDLE) spurious <= 1'b1;

      case (state)
        S_IDLE: if (start) begin
          state          <= S_CALIB;
          busy           <= 1'b1;
          done           <= 1'b0;
          pass           <= 1'b0;
          timeout        <= 1'b0;
          spurious       <= 1'b0;
          err_count      <= 16'd0;
          first_err_addr <= '0;
          interleaved    <= mode[0];
          burst_cnt      <= '0;
          beat_cnt       <= 6'd0;
          app_addr       <= BASE;
        end
        S_CALIB: if (init_calib_complete) begin
          state      <= S_WR_CMD;
          app_cmd_en <= 1'b1;
          app_cmd    <= CMD_WR;
        end
        S_WR_CMD: if (cmd_acc) begin
          state         <= S_WR_DATA;
          app_cmd_en    <= 1'b0;
          app_wdata_en  <= 1'b1;
          app_wdata_end <= (LAST_BEAT == 6'd0);
          beat_cnt      <= 6'd0;
        end
        S_WR_DATA: if (wr_acc) begin
          if (last_beat) begin
            app_wdata_en  <= 1'b0;
            app_wdata_end <= 1'b0;
            beat_cnt      <= 6'd0;
            app_cmd_en    <= 1'b1;
            if (interleaved) begin
              state   <= S_RD_CMD;
              app_cmd <= CMD_RD;
            end else if (last_burst) begin
              state     <= S_RD_CMD;
              app_cmd   <= CMD_RD;
              burst_cnt <= '0;
              app_addr  <= BASE;
            end else begin
              state     <= S_WR_CMD;
              app_cmd   <= CMD_WR;
              burst_cnt <= burst_cnt + BW'(1);
              app_addr  <= app_addr + STRIDE;
            end
          end else begin
            beat_cnt      <= beat_cnt + 6'd1;
            app_wdata_end <= (beat_cnt + 6'd1 == LAST_BEAT);
          end
        end
        S_RD_CMD: if (cmd_acc) begin
          state      <= S_RD_DATA;
          app_cmd_en <= 1'b0;
          beat_cnt   <= 6'd0;
        end
        S_RD_DATA: if (app_rdata_valid) begin
          if (beat_err) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (err_count == 16'd0) first_err_addr <= beat_addr;
          end
          if (last_beat) begin
            beat_cnt <= 6'd0;
            if (last_burst) begin
              state <= S_DONE;
            end else begin
              burst_cnt  <= burst_cnt + BW'(1);
              app_addr   <= app_addr + STRIDE;
              app_cmd_en <= 1'b1;
              state      <= interleaved ? S_WR_CMD : S_RD_CMD;
              app_cmd    <= interleaved ? CMD_WR : CMD_RD;
            end
          end else begin
            beat_cnt <= beat_cnt + 6'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == 16'd0) && !timeout && !spurious;
        end
        default: state <= S_IDLE;
      endcase

      if (tmo_hit) begin
        timeout       <= 1'b1;
        app_cmd_en    <= 1'b0;
        app_wdata_en  <= 1'b0;
        app_wdata_end <= 1'b0;
        state         <= S_DONE;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_app_traffic_gen.sv
// Directed bench for ddr3_app_traffic_gen with a simple app-interface controller model.
module tb_ddr3_app_traffic_gen;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst, start, calib;
  logic [1:0]        mode;
  logic              app_cmd_en, app_cmd_rdy, app_wdata_en, app_wdata_end, app_wdata_rdy;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr, first_err_addr;
  logic [5:0]        app_burst_number;
  logic [DATA_W-1:0] app_wdata, app_rdata;
  logic              app_rdata_valid, app_rdata_end;
  logic              busy, done, pass, timeout, spurious;
  logic [15:0]       err_count;

  // second instance for the address wrap case
  logic              start_w;
  logic              w_cmd_en, w_wdata_en, w_wdata_end, w_busy, w_done, w_pass, w_timeout, w_spurious;
  logic [2:0]        w_cmd;
  logic [ADDR_W-1:0] w_addr, w_first_err;
  logic [5:0]        w_burst_number;
  logic [DATA_W-1:0] w_wdata;
  logic [15:0]       w_err_count;

  always #5 clk = ~clk;

  ddr3_app_traffic_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_BEATS(4), .REGION_BURSTS(8),
                         .ADDR_INC(8), .BASE_ADDR(0), .TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .init_calib_complete(calib),
    .app_cmd_en(app_cmd_en), .app_cmd(app_cmd), .app_cmd_rdy(app_cmd_rdy), .app_addr(app_addr),
    .app_burst_number(app_burst_number), .app_wdata_en(app_wdata_en), .app_wdata_end(app_wdata_end),
    .app_wdata(app_wdata), .app_wdata_rdy(app_wdata_rdy), .app_rdata_valid(app_rdata_valid),
    .app_rdata_end(app_rdata_end), .app_rdata(app_rdata), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .spurious(spurious), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  ddr3_app_traffic_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_BEATS(4), .REGION_BURSTS(2),
                         .ADDR_INC(8), .BASE_ADDR(32'h7FF_FFE0), .TIMEOUT(4096)) dut_wrap (
    .clk(clk), .rst(rst), .start(start_w), .mode(2'b00), .init_calib_complete(1'b1),
    .app_cmd_en(w_cmd_en), .app_cmd(w_cmd), .app_cmd_rdy(1'b1), .app_addr(w_addr),
    .app_burst_number(w_burst_number), .app_wdata_en(w_wdata_en), .app_wdata_end(w_wdata_end),
    .app_wdata(w_wdata), .app_wdata_rdy(1'b1), .app_rdata_valid(1'b0),
    .app_rdata_end(1'b0), .app_rdata('0), .busy(w_busy), .done(w_done), .pass(w_pass),
    .timeout(w_timeout), .spurious(w_spurious), .err_count(w_err_count), .first_err_addr(w_first_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- controller model ----------------
  logic [DATA_W-1:0] mem [0:63];
  int                rdy_mode = 0;
  bit                corrupt = 1'b0;
  int                spur_req = 0, spur_done = 0;
  logic [ADDR_W-1:0] rd_q [$];
  logic [29:0]       cmd_log [$];
  logic [ADDR_W-1:0] w_log [$];
  int                wr_idx = 0, wr_beat = 0, rd_beat = 0;
  bit                rd_active = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  int                stable_err = 0, end_err = 0, acc_beats = 0;
  logic              s_cmd_hs, s_wr_hs, s_wend, s_wen;
  logic [2:0]        s_cmd;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, d;
  logic              prev_cstall = 1'b0, prev_wstall = 1'b0, prev_wend;
  logic [2:0]        prev_cmd;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_wdata;

  initial begin
    app_cmd_rdy = 1'b1; app_wdata_rdy = 1'b1;
    app_rdata_valid = 1'b0; app_rdata_end = 1'b0; app_rdata = '0;
  end

  always @(posedge clk) begin
    s_cmd_hs = app_cmd_en && app_cmd_rdy;
    s_cmd    = app_cmd;
    s_addr   = app_addr;
    s_wr_hs  = app_wdata_en && app_wdata_rdy;
    s_wdata  = app_wdata;
    s_wend   = app_wdata_end;
    s_wen    = app_wdata_en;
    if (prev_cstall && app_cmd_en && (app_cmd != prev_cmd || app_addr != prev_addr)) stable_err++;
    if (prev_wstall && app_wdata_en && (app_wdata != prev_wdata || app_wdata_end != prev_wend)) stable_err++;
    prev_cstall = app_cmd_en && !app_cmd_rdy;
    prev_wstall = app_wdata_en && !app_wdata_rdy;
    prev_cmd = app_cmd; prev_addr = app_addr; prev_wdata = app_wdata; prev_wend = app_wdata_end;
    if (s_cmd_hs) cmd_log.push_back({s_cmd, s_addr});
    if (w_cmd_en && w_cmd == 3'b000) w_log.push_back(w_addr);
    #1;
    app_rdata_valid = 1'b0;
    app_rdata_end   = 1'b0;
    if (rst) begin
      rd_q.delete();
      rd_active = 1'b0;
      wr_beat = 0;
    end else begin
      if (s_wr_hs) begin
        mem[(wr_idx + wr_beat) & 63] = s_wdata;
        if (s_wend != (wr_beat == 3)) end_err++;
        wr_beat++;
        acc_beats++;
      end
      if (s_cmd_hs) begin
        if (s_cmd == 3'b000) begin
          wr_idx  = int'(s_addr >> 3);
          wr_beat = 0;
        end else begin
          rd_q.push_back(s_addr);
        end
      end
      if (!rd_active && rd_q.size() > 0) begin
        rd_addr = rd_q.pop_front();
        rd_beat = 0;
        rd_active = 1'b1;
      end
      if (rd_active) begin
        d = mem[(int'(rd_addr >> 3) + rd_beat) & 63];
        if (corrupt && rd_addr == 27'd96 && rd_beat == 1) d[5] = ~d[5];
        app_rdata       = d;
        app_rdata_valid = 1'b1;
        app_rdata_end   = (rd_beat == 3);
        rd_beat++;
        if (rd_beat == 4) rd_active = 1'b0;
      end else if (spur_req != spur_done && s_wen) begin
        app_rdata       = '0;
        app_rdata_valid = 1'b1;
        spur_done       = spur_req;
      end
    end
    app_cmd_rdy   = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b0;
    app_wdata_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 9) < 3) : 1'b0;
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  initial begin
    int base, n, s0, e0, a0;
    bit saw_cmd;
    rst = 1'b1; start = 1'b0; mode = 2'b00; calib = 1'b1; start_w = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cmd_en", app_cmd_en, 1'b0);
    check("rst_wdata_en", app_wdata_en, 1'b0);
    check("rst_addr", app_addr, 27'd0);
    check("rst_wdata", app_wdata, 0);
    check("rst_err", err_count, 16'd0);
    check("burst_number", app_burst_number, 6'd3);
    rst = 1'b0;
    @(negedge clk);
    start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;

    // sequential counter pass
    base = cmd_log.size();
    pulse_start(2'b00);
    wait_done("seq", 2000);
    check("seq_pass", pass, 1'b1);
    check("seq_err", err_count, 16'd0);
    check("seq_ncmd", cmd_log.size() - base, 16);
    for (int i = 0; i < 16; i++) begin
      check("seq_cmd", cmd_log[base + i],
            (i < 8) ? {3'b000, 27'(i * 32)} : {3'b001, 27'((i - 8) * 32)});
    end

    // address wrap on the second instance
    check("wrap_nwr", w_log.size() >= 2, 1'b1);
    if (w_log.size() >= 2) begin
      check("wrap_addr0", w_log[0], 27'h7FF_FFE0);
      check("wrap_addr1", w_log[1], 27'h000_0000);
    end
    check("wrap_busy", w_busy, 1'b1);

    // interleaved LFSR with one corrupted beat
    corrupt = 1'b1;
    base = cmd_log.size();
    pulse_start(2'b11);
    wait_done("corrupt", 2000);
    corrupt = 1'b0;
    check("corrupt_err", err_count, 16'd1);
    check("corrupt_first", first_err_addr, 27'd104);
    check("corrupt_pass", pass, 1'b0);
    check("il_cmd1", cmd_log[base + 1], {3'b001, 27'd0});
    check("il_cmd2", cmd_log[base + 2], {3'b000, 27'd32});

    // random backpressure
    s0 = stable_err; e0 = end_err; a0 = acc_beats;
    rdy_mode = 1;
    pulse_start(2'b10);
    wait_done("bp", 6000);
    rdy_mode = 0;
    check("bp_pass", pass, 1'b1);
    check("bp_stable", stable_err - s0, 0);
    check("bp_wdata_end", end_err - e0, 0);
    check("bp_beats", acc_beats - a0, 32);

    // timeout: command never accepted
    rdy_mode = 2;
    pulse_start(2'b00);
    n = 0;
    while (!timeout && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_window", (n >= 4096) && (n <= 4110), 1'b1);
    repeat (2) @(negedge clk);
    check("tmo_done", done, 1'b1);
    check("tmo_pass", pass, 1'b0);
    check("tmo_cmd_en", app_cmd_en, 1'b0);
    rdy_mode = 0;

    // late calibration, then a spurious read beat during write data
    calib = 1'b0;
    pulse_start(2'b00);
    saw_cmd = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (app_cmd_en) saw_cmd = 1'b1;
    end
    check("calib_hold", saw_cmd, 1'b0);
    check("calib_busy", busy, 1'b1);
    spur_req++;
    calib = 1'b1;
    wait_done("spur", 2000);
    check("spur_flag", spurious, 1'b1);
    check("spur_pass", pass, 1'b0);
    check("spur_err", err_count, 16'd0);

    // reset in the middle of read data, then a clean restart
    pulse_start(2'b00);
    n = 0;
    while (!app_rdata_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rd_reached", app_rdata_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cmd_en", app_cmd_en, 1'b0);
    check("mid_rst_wdata_en", app_wdata_en, 1'b0);
    check("mid_rst_addr", app_addr, 27'd0);
    check("mid_rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(2'b01);
    wait_done("restart", 2000);
    check("restart_pass", pass, 1'b1);
    check("restart_spur", spurious, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
